// File: rtl/map_render_pkg.sv
// ============================================================================
// Module : map_render_pkg
// Shared game/VGA constants, tile codes and colours for the tile-map renderer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package map_render_pkg;

    // Display geometry (1024x768 active area)
    localparam int HOR_PIXELS = 1024;
    localparam int VER_PIXELS = 768;

    localparam int MAP_WIDTH  = 64;
    localparam int MAP_HEIGHT = 48;
    localparam int SIZE       = HOR_PIXELS / MAP_WIDTH;

    typedef enum logic [1:0] {
        TILE_EMPTY   = 2'd0,
        TILE_PLAYER1 = 2'd1,
        TILE_PLAYER2 = 2'd2,
        TILE_FRAME   = 2'd3
    } tile_t;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    localparam logic [11:0] c_rgb_empty   = 12'h000;
    localparam logic [11:0] c_rgb_player1 = 12'hF0F;
    localparam logic [11:0] c_rgb_player2 = 12'h0F0;
    localparam logic [11:0] c_rgb_frame   = 12'h00F;

    function automatic logic [11:0] tile_rgb(input tile_t t);
        case (t)
            TILE_PLAYER1: return c_rgb_player1;
            TILE_PLAYER2: return c_rgb_player2;
            TILE_FRAME:   return c_rgb_frame;
            default:      return c_rgb_empty;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/map_render_tile_ram.sv
// ============================================================================
// Module : tile_ram
// Simple dual-port tile RAM: one write port, one registered read-first read.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tile_ram #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 2
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] r_rdata;

    // Non-blocking read of the array gives read-first behaviour on collisions
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/map_render.sv
// ============================================================================
// Module : map_render
// 64x48 tile map owner: initialises the map, accepts tile writes, renders RGB.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module map_render
    import map_render_pkg::*;
#(
    parameter int MAP_W      = 64,
    parameter int MAP_H      = 48,
    parameter int TILE_SHIFT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] hcount_in,
    input  logic [10:0] vcount_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        hblnk_in,
    input  logic        vblnk_in,
    output logic [10:0] hcount_out,
    output logic [10:0] vcount_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        hblnk_out,
    output logic        vblnk_out,
    output logic [11:0] rgb_out,
    input  logic        wr_en,
    input  logic [5:0]  wr_x,
    input  logic [5:0]  wr_y,
    input  logic [1:0]  wr_tile,
    output logic        wr_ready,
    input  logic        clear_req,
    output logic        busy
);

    localparam logic [5:0]  c_last_x = 6'(MAP_W - 1);
    localparam logic [5:0]  c_last_y = 6'(MAP_H - 1);
    localparam logic [10:0] c_hor_px = 11'(HOR_PIXELS);
    localparam logic [10:0] c_ver_px = 11'(VER_PIXELS);

    state_t      r_state;
    state_t      w_state_next;
    logic [5:0]  r_clr_x;
    logic [5:0]  r_clr_y;
    logic        w_clr_last;
    logic        w_busy;

    logic        w_we;
    logic [11:0] w_waddr;
    logic [1:0]  w_wdata;
    logic [11:0] w_raddr;
    logic [1:0]  w_rdata;

    logic [10:0] r_hc1, r_vc1, r_hc2, r_vc2;
    logic        r_hs1, r_vs1, r_hb1, r_vb1;
    logic        r_hs2, r_vs2, r_hb2, r_vb2;
    logic [11:0] r_rgb;
    logic        w_blank;

    assign w_busy     = (r_state == ST_CLEAR);
    assign w_clr_last = (r_clr_x == c_last_x) && (r_clr_y == c_last_y);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_CLEAR;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_CLEAR: if (w_clr_last) w_state_next = ST_IDLE;
            ST_IDLE:  if (clear_req)  w_state_next = ST_CLEAR;
            default:  w_state_next = ST_CLEAR;
        endcase
    end

    // Clear counter scans x fastest, wrapping back to (0,0) after the last tile
    always_ff @(posedge clk) begin
        if (rst || !w_busy) begin
            r_clr_x <= '0;
            r_clr_y <= '0;
        end else if (r_clr_x == c_last_x) begin
            r_clr_x <= '0;
            r_clr_y <= (r_clr_y == c_last_y) ? 6'd0 : r_clr_y + 6'd1;
        end else begin
            r_clr_x <= r_clr_x + 6'd1;
        end
    end

    always_comb begin
        w_we    = 1'b0;
        w_waddr = {wr_y, wr_x};
        w_wdata = wr_tile;
        if (w_busy) begin
            w_we    = 1'b1;
            w_waddr = {r_clr_y, r_clr_x};
            if (r_clr_x == 6'd0 || r_clr_x == c_last_x ||
                r_clr_y == 6'd0 || r_clr_y == c_last_y) begin
                w_wdata = TILE_FRAME;
            end else begin
                w_wdata = TILE_EMPTY;
            end
        end else if (wr_en && (wr_y <= c_last_y)) begin
            w_we = 1'b1;
        end
    end

    assign w_raddr = {vcount_in[TILE_SHIFT +: 6], hcount_in[TILE_SHIFT +: 6]};

    tile_ram #(
        .ADDR_W(12),
        .DATA_W(2)
    ) u_tile_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    // Blanking is judged on stage-1 timing so it lines up with the RAM data
    assign w_blank = r_hb1 || r_vb1 || (r_hc1 >= c_hor_px) || (r_vc1 >= c_ver_px);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hc1 <= '0; r_vc1 <= '0; r_hs1 <= 1'b0; r_vs1 <= 1'b0;
            r_hb1 <= 1'b0; r_vb1 <= 1'b0;
            r_hc2 <= '0; r_vc2 <= '0; r_hs2 <= 1'b0; r_vs2 <= 1'b0;
            r_hb2 <= 1'b0; r_vb2 <= 1'b0;
            r_rgb <= '0;
        end else begin
            r_hc1 <= hcount_in; r_vc1 <= vcount_in;
            r_hs1 <= hsync_in;  r_vs1 <= vsync_in;
            r_hb1 <= hblnk_in;  r_vb1 <= vblnk_in;
            r_hc2 <= r_hc1;     r_vc2 <= r_vc1;
            r_hs2 <= r_hs1;     r_vs2 <= r_vs1;
            r_hb2 <= r_hb1;     r_vb2 <= r_vb1;
            r_rgb <= w_blank ? c_rgb_empty : tile_rgb(tile_t'(w_rdata));
        end
    end

    assign hcount_out = r_hc2;
    assign vcount_out = r_vc2;
    assign hsync_out  = r_hs2;
    assign vsync_out  = r_vs2;
    assign hblnk_out  = r_hb2;
    assign vblnk_out  = r_vb2;
    assign rgb_out    = r_rgb;
    assign busy       = w_busy;
    assign wr_ready   = !w_busy;

endmodule

`default_nettype wire

// File: tb/tb_map_render.sv
// ============================================================================
// Module : tb_map_render
// Directed self-checking bench for the tile-map renderer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_map_render;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] hcount_in, vcount_in;
    logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
    logic [10:0] hcount_out, vcount_out;
    logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
    logic [11:0] rgb_out;
    logic        wr_en;
    logic [5:0]  wr_x, wr_y;
    logic [1:0]  wr_tile;
    logic        wr_ready;
    logic        clear_req;
    logic        busy;

    int          n_tests = 0;
    int          n_fail  = 0;

    logic [11:0] prev_exp;
    bit          prev_chk = 1'b0;
    string       prev_tag = "";

    always #5 clk = ~clk;

    map_render #(
        .MAP_W(64),
        .MAP_H(48),
        .TILE_SHIFT(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .hcount_in  (hcount_in),
        .vcount_in  (vcount_in),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .hblnk_in   (hblnk_in),
        .vblnk_in   (vblnk_in),
        .hcount_out (hcount_out),
        .vcount_out (vcount_out),
        .hsync_out  (hsync_out),
        .vsync_out  (vsync_out),
        .hblnk_out  (hblnk_out),
        .vblnk_out  (vblnk_out),
        .rgb_out    (rgb_out),
        .wr_en      (wr_en),
        .wr_x       (wr_x),
        .wr_y       (wr_y),
        .wr_tile    (wr_tile),
        .wr_ready   (wr_ready),
        .clear_req  (clear_req),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: drive render inputs, then check the pixel presented one step earlier
    task automatic step(input int h, input int v, input bit hb, input bit vb,
                        input logic [11:0] e, input bit c, input string tag);
        hcount_in = 11'(h);
        vcount_in = 11'(v);
        hblnk_in  = hb;
        vblnk_in  = vb;
        @(posedge clk);
        #1;
        if (prev_chk) check(prev_tag, {20'd0, rgb_out}, {20'd0, prev_exp});
        prev_exp = e;
        prev_chk = c;
        prev_tag = tag;
    endtask

    task automatic pix(input int h, input int v, input logic [11:0] e, input string tag);
        step(h, v, 1'b0, 1'b0, e, 1'b1, tag);
    endtask

    task automatic idle_step();
        step(0, 0, 1'b0, 1'b0, 12'h000, 1'b0, "");
    endtask

    task automatic write_tile(input int x, input int y, input logic [1:0] t);
        wr_en = 1'b1; wr_x = 6'(x); wr_y = 6'(y); wr_tile = t;
        idle_step();
        wr_en = 1'b0;
    endtask

    task automatic wait_clear(input string tag, input int pulse_at);
        int n = 0;
        while (busy === 1'b1 && n < 4000) begin
            n++;
            clear_req = (n == pulse_at);
            idle_step();
        end
        clear_req = 1'b0;
        check(tag, 32'(n), 32'd3072);
    endtask

    initial begin
        rst = 1'b1; hsync_in = 0; vsync_in = 0; hblnk_in = 0; vblnk_in = 0;
        hcount_in = '0; vcount_in = '0;
        wr_en = 0; wr_x = '0; wr_y = '0; wr_tile = '0; clear_req = 0;

        idle_step();
        rst = 1'b0;
        check("rst_rgb", {20'd0, rgb_out}, 32'h0);
        check("rst_busy", {31'd0, busy}, 32'd1);
        check("rst_wr_ready", {31'd0, wr_ready}, 32'd0);
        check("rst_hcount_out", {21'd0, hcount_out}, 32'd0);
        check("rst_hsync_out", {31'd0, hsync_out}, 32'd0);
        wait_clear("clear_len_initial", -1);
        check("idle_wr_ready", {31'd0, wr_ready}, 32'd1);

        // Frame border and interior after init
        pix(0, 0, 12'h00F, "frame_0_0");
        pix(15, 15, 12'h00F, "frame_15_15");
        pix(16, 16, 12'h000, "interior_16_16");
        pix(1008, 400, 12'h00F, "frame_right");
        pix(1023, 767, 12'h00F, "frame_corner");
        pix(500, 752, 12'h00F, "frame_bottom");
        pix(1007, 751, 12'h000, "interior_edge");
        pix(1024, 0, 12'h000, "outside_h");
        pix(0, 768, 12'h000, "outside_v");
        idle_step();

        // Player tiles
        write_tile(10, 18, 2'd1);
        write_tile(30, 40, 2'd2);
        pix(160, 288, 12'hF0F, "p1_first");
        pix(175, 303, 12'hF0F, "p1_last");
        pix(176, 288, 12'h000, "p1_right_neighbour");
        pix(480, 640, 12'h0F0, "p2_first");
        pix(495, 655, 12'h0F0, "p2_last");
        pix(479, 640, 12'h000, "p2_left_neighbour");
        step(165, 290, 1'b1, 1'b0, 12'h000, 1'b1, "hblnk_over_p1");
        step(165, 290, 1'b0, 1'b1, 12'h000, 1'b1, "vblnk_over_p1");
        idle_step();

        // Strobe delay of exactly two cycles
        hsync_in = 1'b1; vsync_in = 1'b0;
        step(123, 45, 1'b0, 1'b1, 12'h000, 1'b0, "");
        hsync_in = 1'b0;
        check("strobe_not_1cycle", {31'd0, hsync_out}, 32'd0);
        vsync_in = 1'b1;
        step(7, 9, 1'b1, 1'b0, 12'h000, 1'b0, "");
        vsync_in = 1'b0;
        check("hcount_out_d2", {21'd0, hcount_out}, 32'd123);
        check("vcount_out_d2", {21'd0, vcount_out}, 32'd45);
        check("hsync_out_d2", {31'd0, hsync_out}, 32'd1);
        check("vblnk_out_d2", {31'd0, vblnk_out}, 32'd1);
        check("hblnk_out_d2", {31'd0, hblnk_out}, 32'd0);
        idle_step();
        check("hblnk_out_d2b", {31'd0, hblnk_out}, 32'd1);
        check("vsync_out_d2b", {31'd0, vsync_out}, 32'd1);
        check("hcount_out_d2b", {21'd0, hcount_out}, 32'd7);

        // Write coincident with clear request, then a write held through the clear
        wr_en = 1'b1; wr_x = 6'd7; wr_y = 6'd7; wr_tile = 2'd1; clear_req = 1'b1;
        idle_step();
        clear_req = 1'b0;
        wr_x = 6'd20; wr_y = 6'd20; wr_tile = 2'd2;
        check("clear_wr_ready_low", {31'd0, wr_ready}, 32'd0);
        wait_clear("clear_len_with_req", 1500);
        check("held_write_ready", {31'd0, wr_ready}, 32'd1);
        idle_step();
        wr_en = 1'b0;
        pix(112, 112, 12'h000, "clear_overwrites_7_7");
        pix(320, 320, 12'h0F0, "held_write_landed");
        pix(160, 288, 12'h000, "clear_wiped_p1");
        idle_step();

        // Writes to rows >= 48 are dropped
        write_tile(12, 50, 2'd1);
        pix(192, 800, 12'h000, "row50_offscreen");
        idle_step();

        // Read-first collision
        wr_en = 1'b1; wr_x = 6'd5; wr_y = 6'd5; wr_tile = 2'd2;
        pix(80, 80, 12'h000, "collision_old");
        wr_en = 1'b0;
        pix(80, 81, 12'h0F0, "collision_next_row");
        idle_step();

        // Reset in the middle of a clear
        clear_req = 1'b1;
        idle_step();
        clear_req = 1'b0;
        for (int i = 0; i < 1000; i++) idle_step();
        rst = 1'b1;
        idle_step();
        rst = 1'b0;
        check("midclear_rst_rgb", {20'd0, rgb_out}, 32'h0);
        check("midclear_rst_busy", {31'd0, busy}, 32'd1);
        wait_clear("clear_len_after_rst", -1);
        pix(0, 0, 12'h00F, "post_rst_frame");
        idle_step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/map_render.md
# map_render

Tile-map reader and renderer for the two-player light-cycle game. It owns the 64×48 tile map in a dual-port RAM. The game-logic writer updates single tiles through a write port, and this block reads the map in raster order to produce 12-bit RGB from the incoming VGA timing. It sits between the VGA timing generator and the final RGB output stage, and also initialises the map (empty interior, frame border) on reset and on request.

## Interface
Parameters:
- `MAP_W`, 64: tiles per row.
- `MAP_H`, 48: tiles per column.
- `TILE_SHIFT`, 4: log2 of tile size in pixels (16 px; 1024×768 active).

Ports (one clock domain; reset is synchronous and active-high):
- `clk` in 1: system/pixel clock.
- `rst` in 1: synchronous, active-high reset.
- `hcount_in`, `vcount_in` in 11: pixel coordinates from the timing generator.
- `hsync_in`, `vsync_in`, `hblnk_in`, `vblnk_in` in 1: timing strobes.
- `hcount_out`, `vcount_out` out 11: coordinates delayed to match `rgb_out`.
- `hsync_out`, `vsync_out`, `hblnk_out`, `vblnk_out` out 1: delayed strobes.
- `rgb_out` out 12: pixel colour.
- `wr_en` in 1: tile write request.
- `wr_x` in 6: tile column of the write.
- `wr_y` in 6: tile row of the write.
- `wr_tile` in 2: tile code to write.
- `wr_ready` out 1: write accepted when `wr_en && wr_ready`.
- `clear_req` in 1: start map initialisation.
- `busy` out 1: initialisation in progress.

## Operation
- Tile codes: EMPTY=0, PLAYER1=1, PLAYER2=2, FRAME=3.
- Map address is `{y[5:0], x[5:0]}` (12 bits, 4096 entries). Only x<64, y<48 are used.
- FSM has two states, CLEAR and IDLE.
  - Reset enters CLEAR with the counter at 0.
  - CLEAR writes one tile per cycle, advancing x then y. The tile is FRAME when x==0, x==63, y==0 or y==47, and EMPTY otherwise.
  - After writing (63,47), the FSM goes to IDLE.
  - In IDLE, `clear_req`=1 enters CLEAR with the counter at 0.
  - `clear_req` during CLEAR is ignored (no restart).
  - `rst` mid-CLEAR restarts from 0.
- `busy`=1 exactly while in CLEAR. `wr_ready`=!busy.
- `wr_en` with `wr_ready`=0 is dropped; the writer must hold the request.
- An accepted write lands in the RAM on the same clock edge.
- Writes with `wr_y`≥48 are dropped but still count as accepted.
- Render pipeline:
  - Stage 0: address = `{vcount_in>>4, hcount_in>>4}`.
  - Stage 1: registered RAM read.
  - Stage 2: colour mux into `rgb_out` (EMPTY 12'h000, PLAYER1 12'hF0F, PLAYER2 12'h0F0, FRAME 12'h00F).
- `rgb_out`=12'h000 when the delayed `hblnk` or `vblnk` is set, or when the delayed coordinate is outside 1024×768.
- The RAM is read-first: when the render read and a write hit the same address in the same cycle, the read returns the old tile.
- Reads continue during CLEAR, so a partially initialised map is displayed.

## Timing
- Latency: inputs sampled at edge N produce `rgb_out` and all `*_out` at edge N+2. All strobes and counts are delayed exactly 2 cycles.
- Reset values: `rgb_out`=0; all `*_out` strobes and counts are 0; `busy`=1; `wr_ready`=0.
- Clear duration: 3072 cycles. `busy` first reads 1 on the cycle after `rst`, or after `clear_req` is sampled, and falls to 0 on the cycle after the (63,47) write.
- A tile written at edge N is visible to a render address presented at edge N+1 or later. It appears on `rgb_out` two cycles after that address.
- `clear_req` and `wr_en` asserted together in IDLE: the write is accepted and CLEAR starts on the next cycle. The clear overwrites that tile.

## Structure
- Shared game package holds:
  - tile enum, narrowed to `logic [1:0]`, with the codes above;
  - `MAP_WIDTH`/`MAP_HEIGHT`;
  - tile colour constants;
  - `SIZE`, derived from `HOR_PIXELS`.
- VGA constants come from the shared VGA package.
- One sub-module, `tile_ram`: simple dual-port, 4096×2, one write port, one registered read-first read port, no reset on the array.
- The FSM, clear counter, delay line and colour mux live in `map_render`.

## Test plan
- After reset, hold `rst` 1 cycle: `busy`=1 for 3072 cycles, then 0. Scanning the frame then gives 12'h00F on pixel rows 0–15 and 752–767 and on columns 0–15 and 1008–1023; interior pixels are 12'h000.
- In IDLE, write (10,18)=PLAYER1 and (30,40)=PLAYER2: pixels (160..175, 288..303) are 12'hF0F and (480..495, 640..655) are 12'h0F0, each exactly 2 cycles after its hcount.
- Present `hblnk_in`=1 over a PLAYER1 tile: `rgb_out`=0. Check all strobes delayed by exactly 2 cycles against the inputs.
- Hold `wr_en`=1 during CLEAR: it is not accepted until `busy` falls, then it is written once. Assert `clear_req` mid-clear: the total clear stays 3072 cycles.
- Write (5,5)=PLAYER2 on the same cycle the render address equals (5,5): that pixel shows the old colour; the next row of the same tile shows 12'h0F0.
- Assert `rst` at clear count 1000: the clear restarts and `busy` stays 1 for 3072 more cycles; `rgb_out`=0 on the cycle after reset.
